// File: rtl/sw_debounce_if.sv
// Switch conditioning bundle.
//   sw_raw      : raw, asynchronous, bouncing switch levels (into the debouncer)
//   sw_stable   : debounced levels, registered
//   sw_rise     : one-clk pulse per bit on an accepted 0->1
//   sw_fall     : one-clk pulse per bit on an accepted 1->0
//   sample_tick : one-clk pulse per sample period
// master drives sw_raw (board/bench side); slave is the debouncer.
interface sw_debounce_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] sw_stable;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             sample_tick;

    modport master (
        output sw_raw,
        input  sw_stable,
        input  sw_rise,
        input  sw_fall,
        input  sample_tick
    );

    modport slave (
        input  sw_raw,
        output sw_stable,
        output sw_rise,
        output sw_fall,
        output sample_tick
    );
endinterface

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: two-flop synchronizer per bit, a shared sample
// prescaler and a per-bit stability counter. A new level is accepted once it
// has been seen on STABLE_CNT consecutive sample ticks; acceptance produces a
// one-cycle rise/fall pulse aligned with the first cycle of the new level.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   sw    : sw_debounce_if slave (sw_raw in; sw_stable/sw_rise/sw_fall/sample_tick out)
module sw_debounce #(
    parameter int WIDTH      = 16,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sw_debounce_if.slave sw
);
    // Keep both counters at least one bit wide for the degenerate TICK_DIV=1 case.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [PW-1:0]    pre_q,    pre_d;
    logic             tick_q,   tick_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q,   rise_d;
    logic [WIDTH-1:0] fall_q,   fall_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];

    // Prescaler: tick is registered, so it is high the cycle after the wrap.
    always_comb begin
        pre_d  = pre_q + PW'(1);
        tick_d = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Per-bit stability counters. Pulses default low so they last one cycle.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (s2_q[i] == stable_q[i]) begin
                    // Sampled the accepted level again: any pending change was a bounce.
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = s2_q[i];
                    rise_d[i]   = s2_q[i];
                    fall_d[i]   = ~s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= '0;
            s2_q     <= '0;
            pre_q    <= '0;
            tick_q   <= 1'b0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= sw.sw_raw;
            s2_q     <= s1_q;
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw.sw_stable   = stable_q;
    assign sw.sw_rise     = rise_q;
    assign sw.sw_fall     = fall_q;
    assign sw.sample_tick = tick_q;
endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce. Two instances share sw_raw and reset: A uses
// TICK_DIV=4/STABLE_CNT=3, B the boundary TICK_DIV=1/STABLE_CNT=1.
// The reference model keeps the sw_raw history and the list of values seen
// on each sample tick; a bit flips when its last STABLE_CNT tick samples all
// differ from the current accepted level.
module tb_sw_debounce;
    localparam int W    = 16;
    localparam int TD_A = 4;
    localparam int S_A  = 3;
    localparam int TD_B = 1;
    localparam int S_B  = 1;
    localparam int HMAX = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic [W-1:0] raw = '0;

    sw_debounce_if #(.WIDTH(W)) if_a ();
    sw_debounce_if #(.WIDTH(W)) if_b ();
    assign if_a.sw_raw = raw;
    assign if_b.sw_raw = raw;

    sw_debounce #(.WIDTH(W), .TICK_DIV(TD_A), .STABLE_CNT(S_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if_a)
    );
    sw_debounce #(.WIDTH(W), .TICK_DIV(TD_B), .STABLE_CNT(S_B)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (if_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int           n_edge;
    logic [W-1:0] raw_hist [HMAX];
    logic [W-1:0] samp [2][HMAX];
    int           ns [2];
    logic [W-1:0] e_stable [2];
    logic [W-1:0] e_rise [2];
    logic [W-1:0] e_fall [2];
    logic         e_tick [2];

    task automatic model_clear();
        n_edge = 0;
        for (int id = 0; id < 2; id++) begin
            ns[id] = 0;
            e_stable[id] = '0;
            e_rise[id] = '0;
            e_fall[id] = '0;
            e_tick[id] = 1'b0;
        end
    endtask

    // Edge n_edge (counted from reset release) has just happened.
    task automatic model_edge(input int id, input int td, input int s);
        logic [W-1:0] s2;
        bit all_new;
        e_rise[id] = '0;
        e_fall[id] = '0;
        e_tick[id] = ((n_edge % td) == 0);
        // A tick is visible before this edge if edge n_edge-1 produced one.
        if ((n_edge - 1) >= td && ((n_edge - 1) % td) == 0) begin
            // Two synchronizer stages: the value seen is sw_raw from before edge n-2.
            s2 = (n_edge - 2 >= 1) ? raw_hist[n_edge - 2] : '0;
            samp[id][ns[id]] = s2;
            ns[id]++;
            if (ns[id] >= s) begin
                for (int b = 0; b < W; b++) begin
                    all_new = 1'b1;
                    for (int k = ns[id] - s; k < ns[id]; k++)
                        if (samp[id][k][b] == e_stable[id][b]) all_new = 1'b0;
                    if (all_new) begin
                        e_stable[id][b] = ~e_stable[id][b];
                        if (e_stable[id][b]) e_rise[id][b] = 1'b1;
                        else                 e_fall[id][b] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        n_tests++;
        assert ({if_a.sample_tick, if_a.sw_fall, if_a.sw_rise, if_a.sw_stable} ===
                {e_tick[0], e_fall[0], e_rise[0], e_stable[0]})
        else begin
            n_fail++;
            $error("FAIL %s dutA edge=%0d obs{tick,fall,rise,stable}=%h exp=%h", tag, n_edge,
                   {if_a.sample_tick, if_a.sw_fall, if_a.sw_rise, if_a.sw_stable},
                   {e_tick[0], e_fall[0], e_rise[0], e_stable[0]});
        end
        n_tests++;
        assert ({if_b.sample_tick, if_b.sw_fall, if_b.sw_rise, if_b.sw_stable} ===
                {e_tick[1], e_fall[1], e_rise[1], e_stable[1]})
        else begin
            n_fail++;
            $error("FAIL %s dutB edge=%0d obs{tick,fall,rise,stable}=%h exp=%h", tag, n_edge,
                   {if_b.sample_tick, if_b.sw_fall, if_b.sw_rise, if_b.sw_stable},
                   {e_tick[1], e_fall[1], e_rise[1], e_stable[1]});
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One clock: advance the model on the edge, then compare #1 later.
    task automatic step();
        logic [W-1:0] r;
        r = raw;
        @(posedge clk);
        if (rst_n) begin
            if (n_edge >= HMAX - 2) begin
                $display("FAIL model_history edge=%0d limit=%0d", n_edge, HMAX);
                $fatal(1, "history overflow");
            end
            n_edge++;
            raw_hist[n_edge] = r;
            model_edge(0, TD_A, S_A);
            model_edge(1, TD_B, S_B);
        end
        #1;
        check_all(rst_n ? "cycle" : "in_reset");
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all("reset_async");
        repeat (cycles) step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int cnt_a, cnt_b, first, toggles;
    logic prev;
    bit found;

    initial begin
        model_clear();
        raw = '1;
        #2;
        // Reset/idle with every switch high.
        do_reset(5);
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            cnt_a += int'(if_a.sample_tick);
            cnt_b += int'(if_b.sample_tick);
        end
        check_int("tick_count_a", cnt_a, 2);
        check_int("tick_count_b", cnt_b, 8);
        raw = '0;
        repeat (40) step();

        // Clean toggle on bit 2.
        raw[2] = 1'b1;
        first = -1;
        cnt_a = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (if_a.sw_stable[2] && first < 0) first = c;
            cnt_a += int'(if_a.sw_rise[2]);
        end
        check_int("toggle_latency_min", int'(first >= 11), 1);
        check_int("toggle_latency_max", int'(first <= 14 && first > 0), 1);
        check_int("toggle_rise_cycles", cnt_a, 1);
        raw[2] = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            cnt_a += int'(if_a.sw_fall[2]);
        end
        check_int("toggle_fall_cycles", cnt_a, 1);

        // Bounce on bit 0: 1 x6, 0 x5, then 1 held.
        cnt_a = 0;
        toggles = 0;
        prev = if_a.sw_stable[0];
        raw[0] = 1'b1;
        for (int c = 0; c < 41; c++) begin
            if (c == 6)  raw[0] = 1'b0;
            if (c == 11) raw[0] = 1'b1;
            step();
            cnt_a += int'(if_a.sw_rise[0]);
            if (if_a.sw_stable[0] != prev) toggles++;
            prev = if_a.sw_stable[0];
        end
        check_int("bounce_rise_count", cnt_a, 1);
        check_int("bounce_stable_toggles", toggles, 1);
        raw[0] = 1'b0;
        repeat (30) step();
        // Short 1,0,1 burst ending at 0 must be invisible.
        cnt_a = 0;
        for (int c = 0; c < 36; c++) begin
            raw[0] = (c < 6) ? ((c / 2) % 2 == 0) : 1'b0;
            step();
            cnt_a += int'(if_a.sw_rise[0]) + int'(if_a.sw_fall[0]);
        end
        check_int("burst_pulses", cnt_a, 0);
        check_int("burst_stable", int'(if_a.sw_stable[0]), 0);

        // Parallel acceptance of the upper field.
        raw = 16'hFFC0;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            step();
            if (if_a.sw_rise != '0) found = 1'b1;
        end
        check_int("parallel_found", int'(found), 1);
        check_int("parallel_rise", int'(if_a.sw_rise), 32'hFFC0);
        check_int("parallel_stable", int'(if_a.sw_stable), 32'hFFC0);
        step();
        check_int("parallel_rise_gone", int'(if_a.sw_rise), 0);
        raw = '0;
        repeat (30) step();

        // Reset mid-count on bit 1.
        raw[1] = 1'b1;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 20 && cnt_a < 2; c++) begin
            step();
            cnt_a += int'(if_a.sample_tick);
            cnt_b += int'(if_a.sw_rise[1]);
        end
        check_int("midreset_ticks_seen", cnt_a, 2);
        check_int("midreset_no_early_rise", cnt_b, 0);
        do_reset(3);
        first = -1;
        cnt_a = 0;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (if_a.sw_rise[1] && first < 0) first = c;
            cnt_a += int'(if_a.sw_rise[1]);
        end
        check_int("midreset_rise_cycle", first, 13);
        check_int("midreset_rise_count", cnt_a, 1);

        // Boundary instance: three cycles from sw_raw to sw_stable.
        raw[5] = 1'b1;
        first = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (if_b.sw_stable[5] && first < 0) begin
                first = c;
                check_int("b_rise_at_accept", int'(if_b.sw_rise[5]), 1);
            end
        end
        check_int("b_rise_latency", first, 3);
        raw[5] = 1'b0;
        first = -1;
        cnt_b = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (!if_b.sw_stable[5] && first < 0) first = c;
            cnt_b += int'(if_b.sw_fall[5]);
        end
        check_int("b_fall_latency", first, 3);
        check_int("b_fall_cycles", cnt_b, 1);

        // Random bouncing on all bits, checked cycle by cycle against the model.
        for (int seg = 0; seg < 60; seg++) begin
            raw = raw ^ (W'($urandom) & W'($urandom));
            repeat ($urandom_range(1, 20)) step();
        end
        raw = '0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Conditions the raw board slide switches before they reach the switch-decode stage. That stage derives run/pause, reset, clock-speed select, display_op and ram_display_addr from the switches.
- Synchronizes every switch bit to clk and debounces it with a shared sample tick and a per-bit stability counter.
- Outputs a clean level per bit plus one-cycle rise/fall pulses. The speed-select switch then produces exactly one clean edge per physical toggle.

Parameters:
- WIDTH, 16: number of switch bits conditioned.
- TICK_DIV, 100000: clk cycles per sample tick (1 ms at 100 MHz); legal range >= 1.
- STABLE_CNT, 4: consecutive ticks a new value must persist before acceptance; legal range >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw, asynchronous, bouncing switch levels.
- sw_stable  output  WIDTH  debounced switch levels, registered.
- sw_rise  output  WIDTH  one-clk pulse per bit on accepted 0->1.
- sw_fall  output  WIDTH  one-clk pulse per bit on accepted 1->0.
- sample_tick  output  1  one-clk pulse each sample period (debug/bench visibility).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All flops clear asynchronously when rst_n=0 and leave reset on the first clk edge after rst_n=1.
- Reset values: sw_stable=0, sw_rise=0, sw_fall=0, sample_tick=0. Synchronizer flops, prescaler and all per-bit counters are also 0.
- Synchronizer: two flop stages per bit, sw_raw -> s1 -> s2. Debounce logic uses s2 only. This adds 2 cycles of latency.
- Prescaler:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - sample_tick is registered high for the one cycle after the counter equals TICK_DIV-1, so ticks are exactly TICK_DIV cycles apart.
  - With TICK_DIV=1, sample_tick is high every cycle after reset release.
- Per-bit counter: cnt has width clog2(STABLE_CNT+1). It updates only on cycles where sample_tick=1:
  - If s2 == sw_stable: cnt <= 0. This rejects a bounce back to the old value.
  - Else if cnt == STABLE_CNT-1: sw_stable <= s2 and cnt <= 0. In the same edge, sw_rise (if s2=1) or sw_fall (if s2=0) is driven high.
  - Else: cnt <= cnt+1.
- Pulse width: sw_rise/sw_fall are high for exactly one clk cycle, coincident with the first cycle of the new sw_stable value. They are 0 on all other cycles, never both high for one bit, and never high while rst_n=0.
- Latency: from an sw_raw change held steady, sw_stable changes on the STABLE_CNT-th tick whose s2 already shows the new value.
  - Maximum delay: 2 + TICK_DIV*STABLE_CNT cycles.
  - Minimum delay: 2 + TICK_DIV*(STABLE_CNT-1) + 1 cycles.
- Bounce:
  - Any tick sampling the old value restarts the count.
  - Toggles shorter than one tick period that are never sampled are invisible.
- Bit independence: bits are fully independent. Several bits may accept on the same tick, giving multiple pulse bits high in the same cycle.
- Power-up: switches already high at reset release are treated as transitions from 0. They produce sw_rise after the normal debounce delay. This is intentional, so downstream edge logic sees a consistent history.
- Reset mid-count: pending counts are discarded, outputs return to 0, and debouncing restarts from scratch after release.
- No combinational path from sw_raw to any output.

Test Plan (bench parameters TICK_DIV=4, STABLE_CNT=3, WIDTH=16):
- Reset/idle: hold rst_n=0, sw_raw=16'hFFFF -> sw_stable=0, sw_rise=0, sw_fall=0, sample_tick=0 throughout reset. After release, sample_tick pulses every 4 cycles.
- Clean toggle: set sw_raw[2]=1 and hold.
  - sw_stable[2] goes 1 within 2+12 cycles and no earlier than 2+9.
  - sw_rise[2] is high exactly 1 cycle.
  - Returning sw_raw[2] to 0 gives a single 1-cycle sw_fall[2].
- Bounce rejection: on sw_raw[0], drive 1 for 6 cycles, 0 for 5, 1 held.
  - Exactly one sw_rise[0] occurs; sw_stable[0] never toggles twice.
  - A burst of 1,0,1 shorter than 3 ticks, ending at 0, gives sw_stable[0] staying 0 and no pulses.
- Parallel bits: change sw_raw from 16'h0000 to 16'hFFC0 (ram_display_addr field) in one cycle -> sw_stable=16'hFFC0 and sw_rise=16'hFFC0 for the same single cycle.
- Reset mid-count: start a 0->1 on bit 1, assert rst_n=0 after 2 ticks, then release with the input still 1 -> no pulse before reset. A full 3-tick debounce follows, then one sw_rise[1].
- Boundary parameters: rerun with TICK_DIV=1, STABLE_CNT=1 -> sw_stable follows s2 one cycle later (3 cycles after sw_raw). Each change gives a 1-cycle pulse.
